alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a single multi-cycle ALU: accepts one request at a time, strobes the ALU,
// waits for completion or timeout, and holds the result until the writeback side takes it.
module alu_issue_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_int_float,
   input  logic [3:0]  req_op,
   input  logic [1:0]  req_dec0,
   input  logic [31:0] req_a,
   input  logic [1:0]  req_dec1,
   input  logic [31:0] req_b,
   input  logic [4:0]  req_rd,
   output logic        alu_int_float,
   output logic [3:0]  alu_op,
   output logic [1:0]  alu_decoration0,
   output logic [31:0] alu_operand0,
   output logic [1:0]  alu_decoration1,
   output logic [31:0] alu_operand1,
   output logic        alu_start,
   input  logic        alu_ready,
   input  logic [31:0] alu_res,
   input  logic        alu_zero,
   input  logic        alu_neg,
   input  logic        alu_nan,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [31:0] wb_res,
   output logic [4:0]  wb_rd,
   output logic        wb_zero,
   output logic        wb_neg,
   output logic        wb_nan,
   output logic        wb_timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic       accept;
   logic       bypass;
   logic       wait_done;
   logic       wait_expire;

   assign accept      = (state == IDLE) && req_valid;
   // Integer divide by zero never reaches the ALU; the result is synthesised here.
   assign bypass      = !req_int_float && (req_op == 4'b0111) && (req_b == 32'd0);
   assign wait_done   = (state == WAIT) && alu_ready;
   assign wait_expire = (state == WAIT) && !alu_ready && (wait_cnt == WAIT_LAST);

   assign req_ready = (state == IDLE);
   assign alu_start = (state == ISSUE);
   assign wb_valid  = (state == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               state_nxt = bypass ? RESP : ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (wait_done || wait_expire) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (wb_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counter is zero on the first WAIT cycle; reaching TIMEOUT happens on the edge it would wrap to it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 8'd0;
      end else if (state == WAIT) begin
         if (!alu_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end else begin
         wait_cnt <= 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_int_float   <= 1'b0;
         alu_op          <= 4'd0;
         alu_decoration0 <= 2'd0;
         alu_operand0    <= 32'd0;
         alu_decoration1 <= 2'd0;
         alu_operand1    <= 32'd0;
      end else if (accept) begin
         alu_int_float   <= req_int_float;
         alu_op          <= req_op;
         alu_decoration0 <= req_dec0;
         alu_operand0    <= req_a;
         alu_decoration1 <= req_dec1;
         alu_operand1    <= req_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_res     <= 32'd0;
         wb_rd      <= 5'd0;
         wb_zero    <= 1'b0;
         wb_neg     <= 1'b0;
         wb_nan     <= 1'b0;
         wb_timeout <= 1'b0;
      end else begin
         if (accept) begin
            wb_rd <= req_rd;
         end
         if (accept && bypass) begin
            wb_res     <= 32'hFFFF_FFFF;
            wb_zero    <= 1'b0;
            wb_neg     <= 1'b1;
            wb_nan     <= 1'b1;
            wb_timeout <= 1'b0;
         end else if (wait_done) begin
            wb_res     <= alu_res;
            wb_zero    <= alu_zero;
            wb_neg     <= alu_neg;
            wb_nan     <= alu_nan;
            wb_timeout <= 1'b0;
         end else if (wait_expire) begin
            wb_res     <= 32'd0;
            wb_zero    <= 1'b1;
            wb_neg     <= 1'b0;
            wb_nan     <= 1'b1;
            wb_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with TIMEOUT=3: normal issue, bypass, timeout, priority,
// backpressure, reset mid-operation and back-to-back requests.
module tb_alu_issue_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_int_float;
   logic [3:0]  req_op;
   logic [1:0]  req_dec0;
   logic [31:0] req_a;
   logic [1:0]  req_dec1;
   logic [31:0] req_b;
   logic [4:0]  req_rd;
   logic        alu_int_float;
   logic [3:0]  alu_op;
   logic [1:0]  alu_decoration0;
   logic [31:0] alu_operand0;
   logic [1:0]  alu_decoration1;
   logic [31:0] alu_operand1;
   logic        alu_start;
   logic        alu_ready;
   logic [31:0] alu_res;
   logic        alu_zero;
   logic        alu_neg;
   logic        alu_nan;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_res;
   logic [4:0]  wb_rd;
   logic        wb_zero;
   logic        wb_neg;
   logic        wb_nan;
   logic        wb_timeout;

   int n_cmp;
   int n_err;

   alu_issue_ctrl #(.TIMEOUT(3)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_int_float   (req_int_float),
      .req_op          (req_op),
      .req_dec0        (req_dec0),
      .req_a           (req_a),
      .req_dec1        (req_dec1),
      .req_b           (req_b),
      .req_rd          (req_rd),
      .alu_int_float   (alu_int_float),
      .alu_op          (alu_op),
      .alu_decoration0 (alu_decoration0),
      .alu_operand0    (alu_operand0),
      .alu_decoration1 (alu_decoration1),
      .alu_operand1    (alu_operand1),
      .alu_start       (alu_start),
      .alu_ready       (alu_ready),
      .alu_res         (alu_res),
      .alu_zero        (alu_zero),
      .alu_neg         (alu_neg),
      .alu_nan         (alu_nan),
      .wb_valid        (wb_valid),
      .wb_ready        (wb_ready),
      .wb_res          (wb_res),
      .wb_rd           (wb_rd),
      .wb_zero         (wb_zero),
      .wb_neg          (wb_neg),
      .wb_nan          (wb_nan),
      .wb_timeout      (wb_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic fl, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
      req_int_float = fl;
      req_op        = op;
      req_a         = a;
      req_b         = b;
      req_rd        = rd;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_dec0 = 2'd0;
      req_dec1 = 2'd0;
      set_req(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      alu_ready = 1'b0;
      alu_res = 32'd0;
      alu_zero = 1'b0;
      alu_neg = 1'b0;
      alu_nan = 1'b0;
      wb_ready = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_alu_start", alu_start, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_res", wb_res, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_alu_operand0", alu_operand0, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_req_ready", req_ready, 1);

      // ADD, normal path
      set_req(1'b0, 4'b0100, 32'd5, 32'd7, 5'd3);
      req_valid = 1'b1;
      alu_ready = 1'b1;
      alu_res = 32'd12;
      tick();
      req_valid = 1'b0;
      chk("add_start_n", alu_start, 1);
      chk("add_alu_op", alu_op, 4'b0100);
      chk("add_operand0", alu_operand0, 5);
      chk("add_operand1", alu_operand1, 7);
      chk("add_req_ready", req_ready, 0);
      chk("add_wb_valid_n", wb_valid, 0);
      tick();
      chk("add_start_n1", alu_start, 0);
      chk("add_wb_valid_n1", wb_valid, 0);
      tick();
      chk("add_wb_valid_n2", wb_valid, 1);
      chk("add_wb_res", wb_res, 12);
      chk("add_wb_rd", wb_rd, 3);
      chk("add_flags", {wb_zero, wb_neg, wb_nan, wb_timeout}, 0);
      chk("add_start_n2", alu_start, 0);
      wb_ready = 1'b1;
      alu_ready = 1'b0;
      tick();
      wb_ready = 1'b0;
      chk("add_xfer_wb_valid", wb_valid, 0);
      chk("add_xfer_req_ready", req_ready, 1);

      // Integer divide by zero bypass
      set_req(1'b0, 4'b0111, 32'd9, 32'd0, 5'd4);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("div0_start", alu_start, 0);
      chk("div0_wb_valid", wb_valid, 1);
      chk("div0_wb_res", wb_res, 32'hFFFF_FFFF);
      chk("div0_flags", {wb_zero, wb_neg, wb_nan, wb_timeout}, 4'b0110);
      chk("div0_wb_rd", wb_rd, 4);
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      chk("div0_xfer_req_ready", req_ready, 1);

      // Timeout after 3 WAIT cycles
      set_req(1'b0, 4'b0100, 32'd1, 32'd2, 5'd9);
      req_valid = 1'b1;
      alu_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("tmo_wb_valid_early", wb_valid, 0);
      tick();
      chk("tmo_wb_valid", wb_valid, 1);
      chk("tmo_wb_res", wb_res, 0);
      chk("tmo_flags", {wb_zero, wb_neg, wb_nan, wb_timeout}, 4'b1011);
      chk("tmo_wb_rd", wb_rd, 9);
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;

      // alu_ready on the expiring edge wins over timeout
      set_req(1'b1, 4'b0010, 32'd3, 32'd4, 5'd17);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      tick();
      alu_ready = 1'b1;
      alu_res = 32'h55;
      tick();
      alu_ready = 1'b0;
      chk("prio_wb_valid", wb_valid, 1);
      chk("prio_wb_res", wb_res, 32'h55);
      chk("prio_timeout", wb_timeout, 0);
      chk("prio_wb_rd", wb_rd, 17);
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;

      // Backpressure on a negative result
      set_req(1'b0, 4'b0001, 32'd8, 32'd8, 5'd7);
      req_valid = 1'b1;
      alu_ready = 1'b1;
      alu_res = 32'h8000_0000;
      alu_neg = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         alu_res = 32'h1234_0000 + i;
         alu_neg = 1'b0;
         chk("bp_wb_valid", wb_valid, 1);
         chk("bp_wb_res", wb_res, 32'h8000_0000);
         chk("bp_wb_neg", wb_neg, 1);
         chk("bp_req_ready", req_ready, 0);
         tick();
      end
      alu_ready = 1'b0;
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      chk("bp_xfer_wb_valid", wb_valid, 0);
      chk("bp_xfer_req_ready", req_ready, 1);

      // Reset while waiting on the ALU
      set_req(1'b0, 4'b0010, 32'hAA, 32'hBB, 5'd5);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("rstw_alu_op", alu_op, 0);
      chk("rstw_operand0", alu_operand0, 0);
      chk("rstw_wb_rd", wb_rd, 0);
      chk("rstw_alu_start", alu_start, 0);
      chk("rstw_wb_valid", wb_valid, 0);
      tick();
      rst_n = 1'b1;
      alu_ready = 1'b1;
      alu_res = 32'h77;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rstw_no_wb_valid", wb_valid, 0);
         chk("rstw_req_ready", req_ready, 1);
      end
      chk("rstw_wb_res", wb_res, 0);

      // Back-to-back requests held on the request port
      set_req(1'b0, 4'b0011, 32'h11, 32'h22, 5'd1);
      req_valid = 1'b1;
      alu_res = 32'h33;
      tick();
      set_req(1'b0, 4'b0101, 32'h44, 32'h55, 5'd2);
      chk("b2b_a_op", alu_op, 4'b0011);
      tick();
      chk("b2b_a_op_wait", alu_op, 4'b0011);
      tick();
      chk("b2b_a_wb_valid", wb_valid, 1);
      chk("b2b_a_wb_rd", wb_rd, 1);
      chk("b2b_a_wb_res", wb_res, 32'h33);
      chk("b2b_a_req_ready", req_ready, 0);
      tick();
      chk("b2b_a_op_resp", alu_op, 4'b0011);
      chk("b2b_a_operand0_resp", alu_operand0, 32'h11);
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      chk("b2b_idle_req_ready", req_ready, 1);
      chk("b2b_idle_wb_valid", wb_valid, 0);
      chk("b2b_idle_alu_op", alu_op, 4'b0011);
      alu_res = 32'h66;
      tick();
      req_valid = 1'b0;
      chk("b2b_b_op", alu_op, 4'b0101);
      chk("b2b_b_operand0", alu_operand0, 32'h44);
      chk("b2b_b_start", alu_start, 1);
      tick();
      tick();
      chk("b2b_b_wb_valid", wb_valid, 1);
      chk("b2b_b_wb_rd", wb_rd, 2);
      chk("b2b_b_wb_res", wb_res, 32'h66);
      wb_ready = 1'b1;
      alu_ready = 1'b0;
      tick();
      wb_ready = 1'b0;
      chk("b2b_end_req_ready", req_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
